// File: rtl/ifetch.sv
// Instruction fetch unit: issues one word read at a time and buffers returned
// words in a 2-entry queue for decode; a jump flushes the queue and in-flight data.

module ifetch_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic [1:0] count
);
    // The in-flight reservation must keep pushes away from a full queue
    push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == 2'd2)));
endmodule

module ifetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic        pc_step,
    input  logic        jump_sig,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] mem_addr_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic [31:0] q_data_r [2];
    logic [31:0] q_pc_r   [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic        drop_r;
    logic [1:0]  count_r;

    logic        busy_s;
    logic        space_s;
    logic        post_space_s;
    logic        push_s;
    logic        pop_s;
    logic        load_addr_s;
    logic        drop_s;
    logic [1:0]  count_s;
    logic        head_load_s;
    logic [31:0] head_data_s;
    logic [31:0] head_pc_s;

    // Queue bookkeeping; an outstanding fetch reserves one slot
    always_comb begin
        busy_s       = (state_r != ST_IDLE);
        space_s      = (({1'b0, count_r} + {2'b00, busy_s}) < 3'd2);
        push_s       = (state_r == ST_RESP) && mem_rvalid && !drop_r && !jump_sig;
        post_space_s = (({1'b0, count_r} + {2'b00, push_s}) < 3'd2);
        pop_s        = (count_r != 2'd0) && inst_ready && !jump_sig;
        if (jump_sig) begin
            count_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_s = count_r - 2'd1;
        end else begin
            count_s = count_r;
        end
        if ((state_r == ST_RESP) && mem_rvalid) begin
            drop_s = 1'b0;
        end else if (jump_sig && busy_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = drop_r;
        end
    end

    // Next-state logic; a pending request is never withdrawn, even on a flush
    always_comb begin
        state_s     = state_r;
        load_addr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (space_s && !jump_sig) begin
                    state_s     = ST_REQ;
                    load_addr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid && post_space_s && !jump_sig) begin
                    state_s     = ST_REQ;
                    load_addr_s = 1'b1;
                end else if (mem_rvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs decoded from the state register
    always_comb begin
        mem_req = 1'b0;
        pc_step = 1'b0;
        case (state_r)
            ST_REQ: begin
                mem_req = 1'b1;
                pc_step = mem_gnt && !jump_sig;
            end
            default: begin
                mem_req = 1'b0;
                pc_step = 1'b0;
            end
        endcase
    end

    // Head register follows the queue only on push-into-empty or pop
    always_comb begin
        head_load_s = 1'b0;
        head_data_s = mem_rdata;
        head_pc_s   = mem_addr_r;
        if (jump_sig) begin
            head_load_s = 1'b0;
        end else if (pop_s && (count_r == 2'd2)) begin
            head_load_s = 1'b1;
            head_data_s = q_data_r[~rd_ptr_r];
            head_pc_s   = q_pc_r[~rd_ptr_r];
        end else if (push_s && (pop_s || (count_r == 2'd0))) begin
            head_load_s = 1'b1;
        end else begin
            head_load_s = 1'b0;
        end
    end

    // Control state: FSM, request address, drop flag, count and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            mem_addr_r <= 32'd0;
            drop_r     <= 1'b0;
            count_r    <= 2'd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
            count_r <= count_s;
            if (load_addr_s) begin
                mem_addr_r <= pc_in;
            end
            if (jump_sig) begin
                rd_ptr_r <= wr_ptr_r;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ~wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ~rd_ptr_r;
                end
            end
        end
    end

    // Queue storage and the registered head presented to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data_r[0] <= 32'd0;
            q_data_r[1] <= 32'd0;
            q_pc_r[0]   <= 32'd0;
            q_pc_r[1]   <= 32'd0;
            inst_r      <= 32'd0;
            inst_pc_r   <= 32'd0;
        end else begin
            if (push_s) begin
                q_data_r[wr_ptr_r] <= mem_rdata;
                q_pc_r[wr_ptr_r]   <= mem_addr_r;
            end
            if (head_load_s) begin
                inst_r    <= head_data_s;
                inst_pc_r <= head_pc_s;
            end
        end
    end

    assign mem_addr   = mem_addr_r;
    assign inst_valid = (count_r != 2'd0);
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

    ifetch_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .count (count_r)
    );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a memory/PC environment with a transaction-level
// model of the delivered instruction stream (consecutive words from the last jump target).

module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        pc_step;
    logic        jump_sig = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .pc_step    (pc_step),
        .jump_sig   (jump_sig),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // environment knobs
    int gnt_pct = 100;
    int gnt_delay = 0;
    int lat_min = 0;
    int lat_max = 0;
    int rdy_pct = 100;
    int jump_pct = 0;

    // environment / model state
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic [31:0] jump_tgt;
    logic [31:0] pend_addr;
    logic [31:0] wait_addr;
    logic [31:0] last_addr;
    bit          pend;
    bit          jump_now;
    bit          after_jump;
    bit          was_waiting;
    bit          last_req;
    bit          last_step;
    bit          grant;
    int          dly;
    int          req_age;
    int          pops = 0;
    int          grants = 0;
    int          p0;
    int          g0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic env(input int gp, input int gd, input int lmin, input int lmax, input int rp, input int jp);
        gnt_pct   = gp;
        gnt_delay = gd;
        lat_min   = lmin;
        lat_max   = lmax;
        rdy_pct   = rp;
        jump_pct  = jp;
    endtask

    task automatic do_reset(input logic [31:0] start);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_step", 32'(pc_step), 32'd0);
        jump_sig    = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        inst_ready  = 1'b0;
        pc          = start;
        pc_in       = start;
        exp_pc      = start;
        pend        = 1'b0;
        dly         = 0;
        req_age     = 0;
        was_waiting = 1'b0;
        after_jump  = 1'b0;
        jump_now    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, start);
    endtask

    // One clock cycle of environment: drive at negedge, check, then update the model at posedge
    task automatic cycle();
        @(negedge clk);
        if (jump_pct > 0 && $urandom_range(99) < jump_pct) begin
            jump_now = 1'b1;
            jump_tgt = $urandom & 32'h0000_FFFC;
        end
        jump_sig   = jump_now;
        mem_rvalid = pend && (dly == 0);
        mem_rdata  = mem_rvalid ? (pend_addr + 32'h100) : $urandom;
        if (mem_req && jump_now)
            mem_gnt = 1'b1;
        else if (mem_req)
            mem_gnt = (req_age >= gnt_delay) && ($urandom_range(99) < gnt_pct);
        else
            mem_gnt = ($urandom_range(1) == 1);
        inst_ready = ($urandom_range(99) < rdy_pct);
        pc_in      = pc;
        #1;
        grant     = mem_req && mem_gnt;
        last_req  = mem_req;
        last_addr = mem_addr;
        last_step = pc_step;
        chk("pc_step", 32'(pc_step), 32'(grant && !jump_now));
        if (grant && !jump_now)
            chk("gnt_addr", mem_addr, pc);
        if (was_waiting) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, wait_addr);
        end
        if (after_jump)
            chk("flush_valid", 32'(inst_valid), 32'd0);
        if (inst_valid && inst_ready && !jump_now) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, exp_pc + 32'h100);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        was_waiting = mem_req && !mem_gnt;
        wait_addr   = mem_addr;
        @(posedge clk);
        if (mem_rvalid)
            pend = 1'b0;
        if (grant) begin
            pend      = 1'b1;
            pend_addr = last_addr;
            dly       = lat_min + int'($urandom_range(lat_max - lat_min));
            grants++;
        end else if (pend && dly > 0) begin
            dly--;
        end
        req_age = (last_req && !grant) ? req_age + 1 : 0;
        if (jump_now) begin
            pc     = jump_tgt;
            exp_pc = jump_tgt;
        end else if (grant) begin
            pc = pc + 32'd4;
        end
        after_jump = jump_now;
        jump_now   = 1'b0;
    endtask

    initial begin
        // zero-wait memory, decode always ready
        env(100, 0, 0, 0, 100, 0);
        do_reset(32'd0);
        p0 = pops;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("zw_req", 32'(last_req), 32'(i % 2 == 0));
            if (i % 2 == 0)
                chk("zw_addr", last_addr, 32'(4 * (i / 2)));
        end
        chk("zw_pops", 32'(pops - p0), 32'd2);

        // decode stalled: exactly two fetches fill the queue
        do_reset(32'd0);
        env(100, 0, 0, 0, 0, 0);
        g0 = grants;
        repeat (10) cycle();
        chk("bp_grants", 32'(grants - g0), 32'd2);
        chk("bp_req", 32'(last_req), 32'd0);
        #1;
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_inst", inst, 32'h100);
        chk("bp_inst_pc", inst_pc, 32'd0);
        env(100, 0, 0, 0, 100, 0);
        repeat (10) cycle();
        chk("bp_resume", 32'((grants - g0) > 2), 32'd1);

        // grant delayed three cycles
        do_reset(32'd0);
        env(100, 3, 0, 0, 100, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("dly_req", 32'(last_req), 32'(i < 4));
            chk("dly_step", 32'(last_step), 32'(i == 3));
        end

        // jump while a response is outstanding and one word is queued
        do_reset(32'd0);
        env(100, 0, 3, 3, 0, 0);
        repeat (6) cycle();
        jump_now = 1'b1;
        jump_tgt = 32'h40;
        cycle();
        env(100, 0, 0, 0, 100, 0);
        p0 = pops;
        repeat (12) cycle();
        chk("jmp_pops", 32'(pops > p0), 32'd1);

        // jump coinciding with rvalid and pop, then with a grant
        do_reset(32'd0);
        env(100, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        env(100, 0, 0, 0, 100, 0);
        jump_now = 1'b1;
        jump_tgt = 32'h80;
        p0 = pops;
        cycle();
        chk("jr_nopop", 32'(pops - p0), 32'd0);
        cycle();
        jump_now = 1'b1;
        jump_tgt = 32'hC0;
        cycle();
        chk("jg_req", 32'(last_req), 32'd1);
        chk("jg_step", 32'(last_step), 32'd0);
        repeat (12) cycle();
        chk("jg_pops", 32'(pops > p0), 32'd1);

        // reset asserted mid-response with one word queued
        do_reset(32'd0);
        env(100, 0, 3, 3, 0, 0);
        repeat (6) cycle();
        do_reset(32'h200);
        env(100, 0, 0, 0, 100, 0);
        p0 = pops;
        repeat (12) cycle();
        chk("rst_restart", 32'(pops > p0), 32'd1);

        // randomized traffic with jumps
        do_reset(32'h1000);
        env(60, 0, 0, 3, 60, 5);
        p0 = pops;
        repeat (2000) cycle();
        chk("rnd_live", 32'((pops - p0) > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
